// File: rtl/dna_pkg.sv
// Shared constants, widths and state encoding for the DNA port emulator.
package dna_pkg;

  localparam int DNA_W = 57;
  localparam int CNT_W = $clog2(DNA_W + 1);

  localparam logic [DNA_W-1:0] DNA_DEFAULT = 57'h1dc_ba98_7654_3210;

  // Count value reached after a complete read-out, and the one before it
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DNA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOADED   = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_DONE     = 2'd3
  } dna_state_e;

endpackage

// File: rtl/dna_emu_if.sv
// Control and status signals of the DNA emulator, grouped as one bus.
interface dna_emu_if import dna_pkg::*; ();

  logic [DNA_W-1:0] dna_val;
  logic             dna_val_ld;
  logic             dna_srd;
  logic             dna_sen;
  logic             dna_sdi;
  logic             dna_sdo;
  logic [CNT_W-1:0] dna_cnt;
  logic             dna_done;
  logic             dna_ovr;
  logic             dna_busy;

  modport master (
    output dna_val, dna_val_ld, dna_srd, dna_sen, dna_sdi,
    input  dna_sdo, dna_cnt, dna_done, dna_ovr, dna_busy
  );

  modport slave (
    input  dna_val, dna_val_ld, dna_srd, dna_sen, dna_sdi,
    output dna_sdo, dna_cnt, dna_done, dna_ovr, dna_busy
  );

endinterface

// File: rtl/dna_emu_sreg.sv
// 57-bit shift register: parallel load, MSB-first shift, otherwise hold.
module dna_emu_sreg import dna_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             sdi,
  input  logic [DNA_W-1:0] din,
  output logic             sdo
);

  logic [DNA_W-1:0] sreg_q;

  // Load takes priority over shift; serial input enters at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= din;
    end else if (shift) begin
      sreg_q <= {sreg_q[DNA_W-2:0], sdi};
    end
  end

  assign sdo = sreg_q[DNA_W-1];

endmodule

// File: rtl/dna_emu.sv
// DNA port emulator: value register, read/shift control, counter and flags.
module dna_emu import dna_pkg::*; #(
  parameter logic [DNA_W-1:0] DNA_INIT = DNA_DEFAULT
) (
  input logic      sys_clk,
  input logic      sys_nrst,
  dna_emu_if.slave bus
);

  logic [DNA_W-1:0] val_q;
  dna_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             do_read;
  logic             do_shift;

  // A read always wins over a shift requested in the same cycle
  assign do_read  = bus.dna_srd;
  assign do_shift = bus.dna_sen & ~bus.dna_srd;

  // Value register; a same-cycle read still sees the previous content
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      val_q <= DNA_INIT;
    end else if (bus.dna_val_ld) begin
      val_q <= bus.dna_val;
    end
  end

  dna_emu_sreg u_sreg (
    .clk   (sys_clk),
    .rst_n (sys_nrst),
    .load  (do_read),
    .shift (do_shift),
    .sdi   (bus.dna_sdi),
    .din   (val_q),
    .sdo   (bus.dna_sdo)
  );

  // State, counter and flag registers
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next state: shifts count only after a read, otherwise they flag overrun
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (do_read) begin
      state_d = ST_LOADED;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (do_shift) begin
      case (state_q)
        ST_LOADED, ST_SHIFTING: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFTING;
          end
        end
        default: begin
          ovr_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.dna_cnt  = cnt_q;
  assign bus.dna_done = done_q;
  assign bus.dna_ovr  = ovr_q;
  assign bus.dna_busy = (state_q == ST_LOADED) || (state_q == ST_SHIFTING);

  // A completed read-out can never report more shifts than the word holds
  always_ff @(posedge sys_clk) begin
    if (sys_nrst) begin
      assert (cnt_q <= CNT_FULL);
    end
  end

endmodule

// File: tb/tb_dna_emu.sv
// Randomized scoreboard bench for dna_emu with a bit-queue reference model.
module tb_dna_emu;

  localparam logic [56:0] TB_INIT = 57'h1dc_ba98_7654_3210;

  typedef struct {
    logic       sdo;
    logic [5:0] cnt;
    logic       done;
    logic       ovr;
    logic       busy;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_nrst;

  dna_emu_if bus ();

  dna_emu #(.DNA_INIT(TB_INIT)) u_dut (
    .sys_clk  (sys_clk),
    .sys_nrst (sys_nrst),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  exp_t sb[$];
  logic [56:0] cap;

  // Reference model: the shift register is a queue of bits, front = sdo
  logic        mq[$];
  logic [56:0] m_val;
  bit          m_read_ok;
  int          m_shifts;
  bit          m_ovr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    repeat (57) mq.push_back(1'b0);
    m_val     = TB_INIT;
    m_read_ok = 0;
    m_shifts  = 0;
    m_ovr     = 0;
  endtask

  task automatic model_step(input bit ld, input logic [56:0] val, input bit srd,
                            input bit sen, input bit sdi);
    exp_t e;
    bit done;
    done = 0;
    if (srd) begin
      mq.delete();
      for (int i = 56; i >= 0; i--) mq.push_back(m_val[i]);
      m_read_ok = 1;
      m_shifts  = 0;
      m_ovr     = 0;
    end else if (sen) begin
      void'(mq.pop_front());
      mq.push_back(sdi);
      if (m_read_ok && m_shifts < 57) begin
        m_shifts++;
        done = (m_shifts == 57);
      end else begin
        m_ovr = 1;
      end
    end
    if (ld) m_val = val;
    e.sdo  = mq[0];
    e.cnt  = 6'(m_shifts);
    e.done = done;
    e.ovr  = m_ovr;
    e.busy = m_read_ok && (m_shifts < 57);
    sb.push_back(e);
  endtask

  // One clock cycle: drive, capture sdo ahead of a shift, predict, resync
  task automatic apply_stimulus(input bit ld, input logic [56:0] val, input bit srd,
                                input bit sen, input bit sdi);
    bus.dna_val_ld = ld;
    bus.dna_val    = val;
    bus.dna_srd    = srd;
    bus.dna_sen    = sen;
    bus.dna_sdi    = sdi;
    if (sen && !srd) cap = {cap[55:0], bus.dna_sdo};
    @(posedge sys_clk);
    model_step(ld, val, srd, sen, sdi);
    @(negedge sys_clk);
    #1;
  endtask

  task automatic do_read();
    apply_stimulus(0, '0, 1, 0, 1'($urandom));
  endtask

  task automatic do_idle();
    apply_stimulus(0, '0, 0, 0, 1'($urandom));
  endtask

  task automatic do_shifts(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, '0, 0, 1, 1'($urandom));
  endtask

  task automatic do_load(input logic [56:0] v);
    apply_stimulus(1, v, 0, 0, 1'($urandom));
  endtask

  function automatic logic [56:0] rand57();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[56:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_sdo"},  64'(bus.dna_sdo),  0);
    check_output({tag, "_cnt"},  64'(bus.dna_cnt),  0);
    check_output({tag, "_done"}, 64'(bus.dna_done), 0);
    check_output({tag, "_ovr"},  64'(bus.dna_ovr),  0);
    check_output({tag, "_busy"}, 64'(bus.dna_busy), 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh status, compare it
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_nrst === 1'b1 && bus.dna_done === 1'b1) done_seen++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_output("sb_sdo",  64'(bus.dna_sdo),  64'(e.sdo));
      check_output("sb_cnt",  64'(bus.dna_cnt),  64'(e.cnt));
      check_output("sb_done", 64'(bus.dna_done), 64'(e.done));
      check_output("sb_ovr",  64'(bus.dna_ovr),  64'(e.ovr));
      check_output("sb_busy", 64'(bus.dna_busy), 64'(e.busy));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    logic [56:0] v;
    sys_nrst = 1'b0;
    bus.dna_val = '0; bus.dna_val_ld = 0; bus.dna_srd = 0; bus.dna_sen = 0; bus.dna_sdi = 0;
    cap = '0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    #1;
    check_all_zero("reset");
    sys_nrst = 1'b1;

    $display("[TB] default read-out");
    d0 = done_seen;
    do_read();
    check_output("read_sdo_msb", 64'(bus.dna_sdo), 64'(TB_INIT[56]));
    do_shifts(57);
    check_output("word_default", 64'(cap), 64'(TB_INIT));
    check_output("cnt_full", 64'(bus.dna_cnt), 57);
    check_output("ovr_clear", 64'(bus.dna_ovr), 0);
    check_output("done_once", 64'(done_seen - d0), 1);

    $display("[TB] load during read, then read new value");
    apply_stimulus(1, 57'h1, 1, 0, 0);
    do_shifts(57);
    check_output("word_old_on_ld", 64'(cap), 64'(TB_INIT));
    do_read();
    do_shifts(57);
    check_output("word_one", 64'(cap), 64'h1);

    $display("[TB] overrun after full read-out");
    d0 = done_seen;
    apply_stimulus(0, '0, 0, 1, 1);
    apply_stimulus(0, '0, 0, 1, 0);
    apply_stimulus(0, '0, 0, 1, 1);
    check_output("ovr_set", 64'(bus.dna_ovr), 1);
    check_output("cnt_sat", 64'(bus.dna_cnt), 57);
    check_output("no_second_done", 64'(done_seen - d0), 0);
    do_read();
    check_output("ovr_cleared_by_read", 64'(bus.dna_ovr), 0);

    $display("[TB] read and shift together");
    v = rand57();
    do_load(v);
    do_read();
    do_shifts(10);
    apply_stimulus(0, '0, 1, 1, 1);
    check_output("rs_cnt", 64'(bus.dna_cnt), 0);
    check_output("rs_sdo", 64'(bus.dna_sdo), 64'(v[56]));
    check_output("rs_ovr", 64'(bus.dna_ovr), 0);

    $display("[TB] reset mid-stream");
    do_read();
    do_shifts(20);
    sys_nrst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge sys_clk);
    #1;
    sys_nrst = 1'b1;
    apply_stimulus(0, '0, 0, 1, 1);
    check_output("ovr_no_read", 64'(bus.dna_ovr), 1);
    do_read();
    do_shifts(57);
    check_output("word_after_reset", 64'(cap), 64'(TB_INIT));

    $display("[TB] shifts with random gaps");
    for (int k = 0; k < 3; k++) begin
      v = rand57();
      do_load(v);
      d0 = done_seen;
      do_read();
      for (int i = 0; i < 57; i++) begin
        repeat ($urandom_range(0, 5)) do_idle();
        apply_stimulus(0, '0, 0, 1, 1'($urandom));
      end
      repeat (3) do_idle();
      check_output("word_gaps", 64'(cap), 64'(v));
      check_output("done_gaps", 64'(done_seen - d0), 1);
    end

    $display("[TB] random operation mix");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 14) == 0, rand57(), $urandom_range(0, 29) == 0,
                     $urandom_range(0, 2) != 0, 1'($urandom));
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge sys_clk);
    #1;
    check_output("scoreboard_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dna_emu.md
DNA_EMU -- requirements
Module: dna_emu

Interface
REQ-001 Parameter DNA_INIT, default 57'h1dc_ba98_7654_3210, is the value register content after reset.
REQ-002 sys_clk  in  1  single clock; all state changes on rising edge.
REQ-003 sys_nrst  in  1  reset, asynchronous, active-low.
REQ-004 dna_val  in  57  replacement DNA value, sampled when dna_val_ld=1.
REQ-005 dna_val_ld  in  1  value-register load strobe.
REQ-006 dna_srd  in  1  READ: copy value register into the shift register.
REQ-007 dna_sen  in  1  SHIFT: shift the shift register by one bit.
REQ-008 dna_sdi  in  1  serial data in, entering at bit 0 on each shift.
REQ-009 dna_sdo  out  1  serial data out, equal to shift register bit 56.
REQ-010 dna_cnt  out  6  shifts since last READ, saturating at 57.
REQ-011 dna_done  out  1  one-cycle pulse on the 57th shift after a READ.
REQ-012 dna_ovr  out  1  sticky flag: shift with no valid READ or past 57 shifts.
REQ-013 dna_busy  out  1  high in the LOADED and SHIFTING states.

Function
REQ-014 States are IDLE, LOADED, SHIFTING and DONE; IDLE follows reset.
REQ-015 dna_val_ld=1 writes dna_val into the 57-bit value register; the new value is visible to a READ from the next cycle.
REQ-016 dna_srd=1: shift register <= value register; dna_cnt <= 0; dna_ovr <= 0; next state LOADED; this applies from any state.
REQ-017 dna_srd=1 with dna_sen=1 in the same cycle: READ wins, no shift occurs, and no flag is set.
REQ-018 dna_srd=1 with dna_val_ld=1 in the same cycle: the shift register receives the old value register content.
REQ-019 dna_sen=1 with dna_srd=0: shift register <= {sreg[55:0], dna_sdi} in every state.
REQ-020 On a shift in LOADED or SHIFTING, dna_cnt increments; the state goes LOADED->SHIFTING on the first shift.
REQ-021 The shift that takes dna_cnt from 56 to 57 asserts dna_done for exactly one cycle, registered with that edge, and moves the state to DONE.
REQ-022 A shift in DONE or IDLE sets dna_ovr; dna_cnt holds; the state is unchanged.
REQ-023 dna_sdo is driven directly from a flop with no combinational path from inputs: bit 56 is valid the cycle after a READ, and the next bit is valid the cycle after each shift.
REQ-024 With dna_srd=0 and dna_sen=0, the shift register, dna_cnt and the state hold.
REQ-025 Deasserting dna_sen mid-stream holds the position; resuming continues from that bit with no loss.

Reset
REQ-026 Asserting sys_nrst low, at any time including mid-shift, immediately sets: state IDLE, shift register 0, dna_sdo 0, dna_cnt 0, dna_done 0, dna_ovr 0, dna_busy 0, and value register DNA_INIT.
REQ-027 Release of reset is synchronous to sys_clk; the first READ is accepted on the first edge after release.

Structure
REQ-028 Shared package dna_pkg holds DNA_W=57, the default DNA value constant, and the state encoding; the 6-bit count width derives from DNA_W.
REQ-029 Sub-module dna_emu_sreg holds the 57-bit shift register with load, shift and hold controls; control, counter and flags stay in dna_emu.

Verification
REQ-030 Reset, then READ for 1 cycle, then 57 SHIFT cycles capturing dna_sdo -> captured word 57'h1dc_ba98_7654_3210; dna_done pulses on the 57th shift; dna_cnt=57; dna_ovr=0.
REQ-031 dna_val_ld with 57'h0_0000_0000_0001, then READ, then 57 shifts -> 56 zeros then a 1; a READ in the same cycle as dna_val_ld returns DNA_INIT.
REQ-032 READ, 57 shifts, then 3 more shifts with dna_sdi=1,0,1 -> dna_ovr=1, dna_cnt stays 57, no second dna_done; the next READ clears dna_ovr.
REQ-033 dna_srd=1 and dna_sen=1 together after 10 shifts -> dna_cnt=0, dna_sdo=bit 56 of the value register, no shift.
REQ-034 Reset asserted after 20 shifts -> all outputs 0 immediately, state IDLE; a shift without a READ then sets dna_ovr.
REQ-035 Random dna_sen gaps, 0-5 idle cycles between shifts, over a full read -> captured word matches the value register and dna_done pulses once.
